stack_cpu_driver: RTL and testbench

//  Host-side command streamer for stack_cpu, on the same clock.

---
 rtl/stack_cpu_driver_if.sv | 15 +
 rtl/stack_cpu_driver.sv | 118 +++++++++++
 tb/tb_stack_cpu_driver.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/stack_cpu_driver_if.sv
// stack_cpu_driver_if: host command handshake bundle for stack_cpu_driver
// Signals:
//   cmd_valid  host -> driver  command valid
//   cmd_ready  driver -> host  command FIFO can accept
//   cmd_op     host -> driver  stack_cpu opcode
//   cmd_arg    host -> driver  operand nibble
// Modports: master (host side), slave (driver side).
interface stack_cpu_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [3:0] cmd_arg;
  modport master(output cmd_valid, cmd_op, cmd_arg, input cmd_ready);
  modport slave(input cmd_valid, cmd_op, cmd_arg, output cmd_ready);
endinterface

// File: rtl/stack_cpu_driver.sv
// stack_cpu_driver: buffers host commands and streams them to stack_cpu as timed instruction nibbles
// Ports:
//   i_clk, i_rst_n       shared clock, asynchronous active-low reset
//   cmd                  command handshake (stack_cpu_driver_if.slave)
//   i_mode_sel           requested CPU output mode
//   i_cpu_io_out         CPU io_out, sampled only for readback
//   o_cpu_rst            registered active-high CPU reset
//   o_cpu_inbits         registered instruction nibble to CPU io_in[5:2]
//   o_cpu_output_mode    CPU io_in[7:6]
//   o_busy               FIFO non-empty or real instruction in flight
//   o_rb_data/o_rb_valid readback value and one-cycle strobe
// Build option: define STACK_DRV_READBACK_EN to capture io_out after OUTL/OUTH.
module stack_cpu_driver #(
  parameter int DEPTH        = 4,
  parameter int RESET_CYCLES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  stack_cpu_driver_if.slave  cmd,
  input  logic [1:0]         i_mode_sel,
  input  logic [7:0]         i_cpu_io_out,
  output logic               o_cpu_rst,
  output logic [3:0]         o_cpu_inbits,
  output logic [1:0]         o_cpu_output_mode,
  output logic               o_busy,
  output logic [7:0]         o_rb_data,
  output logic               o_rb_valid
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  typedef enum logic [1:0] {RST_CPU, FETCH, EXEC} state_t;
  state_t      r_state, w_state_nxt;
  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic [RW-1:0] r_rcnt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  r_op, r_arg, w_op_nxt, w_arg_nxt, w_inbits_nxt, w_head_op, w_head_arg;
  logic        r_inflight, w_inflight_nxt;
  logic        w_empty, w_full, w_push, w_pop, w_to_fetch;
  // Exec cycles following the fetch cycle.
  function automatic logic [1:0] exec_len(input logic [3:0] op);
    return op == 4'd9 ? 2'd3 : (op inside {4'd1, 4'd2, [4'd5:4'd8]}) ? 2'd2 : 2'd1;
  endfunction
  function automatic logic uses_arg(input logic [3:0] op);
    return op inside {4'd1, [4'd6:4'd8]};
  endfunction
  assign w_empty = r_wp == r_rp;
  assign w_full = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign cmd.cmd_ready = !w_full && r_state != RST_CPU;
  assign w_push = cmd.cmd_valid && cmd.cmd_ready;
  assign {w_head_op, w_head_arg} = r_mem[r_rp[AW-1:0]];
  assign o_busy = !w_empty || r_inflight;
  // Outputs are registered, so everything a cycle shows is decided on the edge
  // entering it: the FIFO pops on the edge into FETCH, not during FETCH.
  always_comb begin
    w_to_fetch = (r_state == RST_CPU && r_rcnt == RW'(RESET_CYCLES - 1)) ||
                 (r_state == EXEC && r_cnt == 2'd0);
    w_pop = w_to_fetch && !w_empty;
    w_state_nxt = w_to_fetch ? FETCH : r_state == FETCH ? EXEC : r_state;
    w_op_nxt = w_to_fetch ? (w_pop ? w_head_op : 4'h0) : r_op;
    w_arg_nxt = w_to_fetch ? (w_pop ? w_head_arg : 4'h0) : r_arg;
    w_cnt_nxt = w_to_fetch ? (w_pop ? exec_len(w_head_op) : 2'd1) : r_cnt - 2'd1;
    w_inflight_nxt = w_to_fetch ? w_pop : r_inflight;
    w_inbits_nxt = w_to_fetch ? w_op_nxt :
                   (r_state != RST_CPU && uses_arg(r_op)) ? r_arg : 4'h0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state      <= RST_CPU;
      r_rcnt       <= '0;
      r_cnt        <= '0;
      r_op         <= '0;
      r_arg        <= '0;
      r_inflight   <= 1'b0;
      r_wp         <= '0;
      r_rp         <= '0;
      o_cpu_rst    <= 1'b1;
      o_cpu_inbits <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rcnt       <= r_state == RST_CPU ? r_rcnt + 1'b1 : '0;
      r_cnt        <= w_cnt_nxt;
      r_op         <= w_op_nxt;
      r_arg        <= w_arg_nxt;
      r_inflight   <= w_inflight_nxt;
      o_cpu_rst    <= w_state_nxt == RST_CPU;
      o_cpu_inbits <= w_inbits_nxt;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
    end
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wp[AW-1:0]] <= {cmd.cmd_op, cmd.cmd_arg};
`ifdef STACK_DRV_READBACK_EN
  localparam logic [3:0] OP_OUTL = 4'd3;
  localparam logic [3:0] OP_OUTH = 4'd4;
  logic r_rb_pend;
  logic w_unused;
  assign w_unused = ^i_mode_sel;
  assign o_cpu_output_mode = 2'b00;
  // The CPU drives io_out one cycle after OUTL/OUTH completes; sample at the end of that cycle.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_rb_pend  <= 1'b0;
      o_rb_valid <= 1'b0;
      o_rb_data  <= '0;
    end else begin
      r_rb_pend  <= r_state == EXEC && r_cnt == 2'd0 && (r_op == OP_OUTL || r_op == OP_OUTH);
      o_rb_valid <= r_rb_pend;
      if (r_rb_pend) o_rb_data <= i_cpu_io_out;
    end
`else
  logic w_unused;
  assign w_unused = ^i_cpu_io_out;
  assign o_cpu_output_mode = i_mode_sel;
  assign o_rb_data = '0;
  assign o_rb_valid = 1'b0;
`endif
endmodule

// File: tb/tb_stack_cpu_driver.sv
// tb_stack_cpu_driver: directed self-checking bench for stack_cpu_driver
module tb_stack_cpu_driver;
`ifdef STACK_DRV_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] mode_sel = 2'b10;
  logic [7:0] io_out = 8'h07;
  logic       cpu_rst, busy, rb_valid;
  logic [3:0] inbits;
  logic [1:0] omode;
  logic [7:0] rb_data;
  int         n_tests = 0;
  int         n_fail = 0;
  logic       saw_block = 1'b0;
  logic       logging = 1'b0;
  logic [3:0] nib_q[$];
  logic       rbv_q[$];
  logic [7:0] rbd_q[$];
  stack_cpu_driver_if ifc();
  stack_cpu_driver dut (
    .i_clk(clk), .i_rst_n(rst_n), .cmd(ifc.slave), .i_mode_sel(mode_sel),
    .i_cpu_io_out(io_out), .o_cpu_rst(cpu_rst), .o_cpu_inbits(inbits),
    .o_cpu_output_mode(omode), .o_busy(busy), .o_rb_data(rb_data), .o_rb_valid(rb_valid)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (logging) begin
      nib_q.push_back(inbits);
      rbv_q.push_back(rb_valid);
      rbd_q.push_back(rb_data);
    end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic send(input logic [3:0] op, input logic [3:0] arg);
    int n = 0;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op = op;
    ifc.cmd_arg = arg;
    while (!ifc.cmd_ready && n < 50) begin
      saw_block = 1'b1;
      @(negedge clk);
      n++;
    end
    if (!ifc.cmd_ready) check("send_ready", ifc.cmd_ready, 1'b1);
    else begin
      @(posedge clk);
      @(negedge clk);
    end
    ifc.cmd_valid = 1'b0;
  endtask
  task automatic start_log;
    nib_q.delete();
    rbv_q.delete();
    rbd_q.delete();
    logging = 1'b1;
  endtask
  task automatic check_stream(input string tag, input logic [3:0] exp_q[$], output int idx);
    idx = -1;
    foreach (nib_q[i]) if (idx < 0 && nib_q[i] != 4'h0) idx = i;
    check({tag, "_start"}, 32'(idx >= 0), 1);
    if (idx >= 0)
      foreach (exp_q[i])
        check(tag, (idx + i < nib_q.size()) ? 32'(nib_q[idx + i]) : 32'hdead, 32'(exp_q[i]));
  endtask
  task automatic count_nz(input string tag);
    int nz = 0;
    foreach (nib_q[i]) if (nib_q[i] != 4'h0) nz++;
    check(tag, nz, 0);
  endtask
  initial begin
    int idx, pulses, n;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op = 4'h0;
    ifc.cmd_arg = 4'h0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cpu_rst", cpu_rst, 1'b1);
    check("rst_inbits", inbits, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ifc.cmd_ready, 1'b0);
    check("rst_rb_valid", rb_valid, 1'b0);
    check("rst_rb_data", rb_data, 8'h00);
    check("mode", omode, RB ? 2'b00 : 2'b10);
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_cpu_rst_c1", cpu_rst, 1'b1);
    check("t1_ready_c1", ifc.cmd_ready, 1'b0);
    @(negedge clk);
    check("t1_cpu_rst_c2", cpu_rst, 1'b0);
    check("t1_ready_c2", ifc.cmd_ready, 1'b1);
    check("t1_busy", busy, 1'b0);
    start_log();
    repeat (8) @(negedge clk);
    logging = 1'b0;
    count_nz("t1_noop");
    start_log();
    send(4'h1, 4'h3);
    send(4'h1, 4'h5);
    send(4'h8, 4'h0);
    repeat (16) @(negedge clk);
    logging = 1'b0;
    check_stream("t2_nib", '{4'h1, 4'h3, 4'h3, 4'h1, 4'h5, 4'h5, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0}, idx);
    check("t2_busy_end", busy, 1'b0);
    start_log();
    send(4'h1, 4'h3);
    send(4'h1, 4'h4);
    send(4'h9, 4'h0);
    repeat (16) @(negedge clk);
    logging = 1'b0;
    check_stream("t3_nib", '{4'h1, 4'h3, 4'h3, 4'h1, 4'h4, 4'h4, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}, idx);
    start_log();
    saw_block = 1'b0;
    for (int i = 1; i <= 6; i++) send(4'h1, 4'(i));
    check("t4_busy", busy, 1'b1);
    check("t4_full_seen", saw_block, 1'b1);
    repeat (24) @(negedge clk);
    logging = 1'b0;
    check_stream("t4_nib", '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h1, 4'h3, 4'h3,
                             4'h1, 4'h4, 4'h4, 4'h1, 4'h5, 4'h5, 4'h1, 4'h6, 4'h6, 4'h0, 4'h0}, idx);
    check("t4_busy_end", busy, 1'b0);
    start_log();
    send(4'h1, 4'h7);
    send(4'h3, 4'h0);
    repeat (14) @(negedge clk);
    logging = 1'b0;
    check_stream("t5_nib", '{4'h1, 4'h7, 4'h7, 4'h3, 4'h0, 4'h0, 4'h0}, idx);
    pulses = 0;
    foreach (rbv_q[i]) if (rbv_q[i]) pulses++;
    check("t5_pulses", pulses, RB ? 1 : 0);
    if (idx >= 0 && idx + 6 < rbv_q.size()) begin
      check("t5_rb_valid_pos", rbv_q[idx + 6], RB);
      check("t5_rb_data", rbd_q[idx + 6], RB ? 8'h07 : 8'h00);
    end else check("t5_window", idx + 6, 32'(rbv_q.size()));
    send(4'h9, 4'h0);
    send(4'h1, 4'h5);
    n = 0;
    while (inbits != 4'h9 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("t6_mult_seen", inbits, 4'h9);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_cpu_rst", cpu_rst, 1'b1);
    check("t6_inbits", inbits, 4'h0);
    check("t6_busy", busy, 1'b0);
    check("t6_ready", ifc.cmd_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_cpu_rst_c1", cpu_rst, 1'b1);
    @(negedge clk);
    check("t6_cpu_rst_c2", cpu_rst, 1'b0);
    start_log();
    repeat (10) @(negedge clk);
    logging = 1'b0;
    count_nz("t6_noop");
    check("t6_busy_end", busy, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
